// File: rtl/if_id_stage_ctrl.sv
// Front-end pipeline control: owns the PC and the IF/ID register, and turns
// hazard-unit stall/flush requests into freeze, bubble and redirect actions.
module if_id_stage_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int unsigned MAX_STALL = 16,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             PCSrcE,
   input  logic [31:0]      PCTargetE,
   input  logic [31:0]      InstrF,
   output logic [31:0]      PCF,
   output logic [31:0]      PCPlus4F,
   output logic [31:0]      InstrD,
   output logic [31:0]      PCD,
   output logic [31:0]      PCPlus4D,
   output logic             ValidD,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt,
   output logic             StallTimeout
);

   localparam int unsigned RUN_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      TRIPPED = 2'd2
   } wdState_e;

   wdState_e         stateQ;
   wdState_e         stateNext;
   logic [RUN_W-1:0] runQ;
   logic [RUN_W-1:0] runNext;
   logic [RUN_W-1:0] runInc;
   logic             timeoutNext;
   logic             stallEvt;

   // A redirect overrides a fetch stall, so only un-redirected stalls count.
   assign stallEvt = StallF & ~PCSrcE;
   assign runInc   = runQ + RUN_W'(1);
   assign PCPlus4F = PCF + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PCF <= RESET_PC;
      end else if (PCSrcE) begin
         PCF <= PCTargetE;
      end else if (!StallF) begin
         PCF <= PCPlus4F;
      end
   end

   // IF/ID register: flush beats freeze; a flush leaves a bubble in Decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         InstrD   <= NOP_INSTR;
         PCD      <= 32'd0;
         PCPlus4D <= 32'd0;
         ValidD   <= 1'b0;
      end else if (PCSrcE) begin
         InstrD   <= NOP_INSTR;
         PCD      <= 32'd0;
         PCPlus4D <= 32'd0;
         ValidD   <= 1'b0;
      end else if (!StallD) begin
         InstrD   <= InstrF;
         PCD      <= PCF;
         PCPlus4D <= PCPlus4F;
         ValidD   <= 1'b1;
      end
   end

   // Saturating hazard performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (stallEvt && (StallCnt != {CNT_W{1'b1}})) begin
            StallCnt <= StallCnt + CNT_W'(1);
         end
         if (PCSrcE && (FlushCnt != {CNT_W{1'b1}})) begin
            FlushCnt <= FlushCnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ       <= IDLE;
         runQ         <= '0;
         StallTimeout <= 1'b0;
      end else begin
         stateQ       <= stateNext;
         runQ         <= runNext;
         StallTimeout <= timeoutNext;
      end
   end

   // Watchdog next state: trips on the edge where the run length hits MAX_STALL.
   always_comb begin
      stateNext = stateQ;
      case (stateQ)
         IDLE, COUNT: begin
            if (stallEvt) begin
               stateNext = (runInc == RUN_W'(MAX_STALL)) ? TRIPPED : COUNT;
            end else begin
               stateNext = IDLE;
            end
         end
         TRIPPED: stateNext = TRIPPED;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      runNext     = runQ;
      timeoutNext = StallTimeout;
      case (stateQ)
         IDLE, COUNT: begin
            runNext     = stallEvt ? runInc : '0;
            timeoutNext = StallTimeout | (stateNext == TRIPPED);
         end
         TRIPPED: begin
            runNext     = stallEvt ? runQ : '0;
            timeoutNext = 1'b1;
         end
         default: begin
            runNext     = '0;
            timeoutNext = StallTimeout;
         end
      endcase
   end

endmodule

// File: tb/tb_if_id_stage_ctrl.sv
// Scoreboard bench for if_id_stage_ctrl: a cycle-level reference model
// predicts the post-edge state, and a monitor compares it after each edge.
module tb_if_id_stage_ctrl;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int          MAXS      = 16;

   logic        clk;
   logic        rst_n;
   logic        StallF, StallD, PCSrcE;
   logic [31:0] PCTargetE, InstrF;
   logic [31:0] PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
   logic        ValidD;
   logic [31:0] StallCnt, FlushCnt;
   logic        StallTimeout;

   if_id_stage_ctrl #(
      .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .MAX_STALL(MAXS), .CNT_W(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
      .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCD(PCD),
      .PCPlus4D(PCPlus4D), .ValidD(ValidD), .StallCnt(StallCnt),
      .FlushCnt(FlushCnt), .StallTimeout(StallTimeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: content derived from the address.
   function automatic logic [31:0] imem(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
   endfunction
   assign InstrF = imem(PCF);

   typedef struct {
      logic [31:0] pc, instrD, pcD, pcp4D, stallCnt, flushCnt;
      logic        validD, timeout;
   } exp_t;

   exp_t q[$];
   int   nCmp = 0;
   int   nBad = 0;

   logic [31:0] mPc, mInstrD, mPcD, mPcp4D;
   logic        mValid, mTripped;
   longint      mStallCnt, mFlushCnt;
   int          mRun;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nCmp++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mPc = RESET_PC; mInstrD = NOP_INSTR; mPcD = 0; mPcp4D = 0; mValid = 0;
      mStallCnt = 0; mFlushCnt = 0; mRun = 0; mTripped = 0;
   endtask

   task automatic checkResetValues(input string tag);
      chk({tag, ".PCF"}, PCF, RESET_PC);
      chk({tag, ".PCPlus4F"}, PCPlus4F, RESET_PC + 32'd4);
      chk({tag, ".InstrD"}, InstrD, NOP_INSTR);
      chk({tag, ".PCD"}, PCD, 32'd0);
      chk({tag, ".PCPlus4D"}, PCPlus4D, 32'd0);
      chk({tag, ".ValidD"}, 32'(ValidD), 32'd0);
      chk({tag, ".StallCnt"}, StallCnt, 32'd0);
      chk({tag, ".FlushCnt"}, FlushCnt, 32'd0);
      chk({tag, ".StallTimeout"}, 32'(StallTimeout), 32'd0);
   endtask

   // Drive one cycle starting at a negedge; ends at the next negedge.
   task automatic step(input logic sf, input logic sd, input logic pcs, input logic [31:0] tgt);
      exp_t e;
      StallF = sf; StallD = sd; PCSrcE = pcs; PCTargetE = tgt;
      if (pcs) begin
         mInstrD = NOP_INSTR; mPcD = 0; mPcp4D = 0; mValid = 0;
      end else if (!sd) begin
         mInstrD = imem(mPc); mPcD = mPc; mPcp4D = mPc + 32'd4; mValid = 1;
      end
      if (sf && !pcs) begin
         if (mStallCnt < 64'hFFFF_FFFF) mStallCnt++;
         if (!mTripped) begin
            mRun++;
            if (mRun == MAXS) mTripped = 1;
         end
      end else begin
         mRun = 0;
      end
      if (pcs && mFlushCnt < 64'hFFFF_FFFF) mFlushCnt++;
      if (pcs)      mPc = tgt;
      else if (!sf) mPc = mPc + 32'd4;
      e.pc = mPc; e.instrD = mInstrD; e.pcD = mPcD; e.pcp4D = mPcp4D;
      e.validD = mValid; e.stallCnt = 32'(mStallCnt); e.flushCnt = 32'(mFlushCnt);
      e.timeout = mTripped;
      q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: compares the DUT against the oldest prediction after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("PCF", PCF, e.pc);
            chk("PCPlus4F", PCPlus4F, e.pc + 32'd4);
            chk("InstrD", InstrD, e.instrD);
            chk("PCD", PCD, e.pcD);
            chk("PCPlus4D", PCPlus4D, e.pcp4D);
            chk("ValidD", 32'(ValidD), 32'(e.validD));
            chk("StallCnt", StallCnt, e.stallCnt);
            chk("FlushCnt", FlushCnt, e.flushCnt);
            chk("StallTimeout", 32'(StallTimeout), 32'(e.timeout));
         end
      end
   end

   initial begin
      logic sf, sd, pcs;
      int   drain;
      rst_n = 1'b0; StallF = 0; StallD = 0; PCSrcE = 0; PCTargetE = 0;
      modelReset();
      @(negedge clk); @(negedge clk);
      #1 checkResetValues("reset");
      @(negedge clk);
      rst_n = 1'b1;

      repeat (2) step(0, 0, 0, 0);                 // PCF reaches 8
      step(1, 1, 0, 0);                            // single load-use stall
      repeat (2) step(0, 0, 0, 0);
      step(1, 1, 1, 32'h0000_0100);                // redirect beats stall
      step(0, 0, 0, 0);
      step(0, 0, 1, 32'hFFFF_FFFC);                // wrap boundary
      repeat (3) step(0, 0, 0, 0);
      step(1, 0, 0, 0);                            // StallF only: Decode re-captures
      step(0, 0, 0, 0);

      repeat (MAXS - 1) step(1, 1, 0, 0);          // one short of the limit
      repeat (2) step(0, 0, 0, 0);
      repeat (MAXS - 1) step(1, 1, 0, 0);
      step(0, 0, 1, 32'h0000_0200);                // redirect clears the run
      repeat (MAXS) step(1, 1, 0, 0);              // trips on the last edge
      repeat (3) step(0, 0, 0, 0);

      for (int i = 0; i < 300; i++) begin
         sf  = ($urandom_range(0, 3) == 0);
         sd  = ($urandom_range(0, 7) == 0) ? ~sf : sf;
         pcs = ($urandom_range(0, 7) == 0);
         step(sf, sd, pcs, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      end

      repeat (5) step(1, 1, 0, 0);
      #2 rst_n = 1'b0;                             // async reset mid-stall
      #1 checkResetValues("asyncReset");
      modelReset();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 200; i++) begin
         sf  = ($urandom_range(0, 2) == 0);
         sd  = sf;
         pcs = ($urandom_range(0, 9) == 0);
         step(sf, sd, pcs, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      end
      repeat (MAXS + 2) step(1, 0, 0, 0);
      step(0, 0, 0, 0);

      drain = 0;
      while (q.size() > 0 && drain < 5) begin
         @(negedge clk);
         drain++;
      end
      if (q.size() > 0) begin
         nCmp++; nBad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
